// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM controller between the instruction-fetch path
// and the load/store data path. One transaction in flight at a time; data has
// priority, fetch is protected by a starvation counter, and a watchdog aborts
// transactions the controller never completes.
module mem_arbiter #(
  parameter int STARVE_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  // instruction-fetch requester
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic        i_err,
  output logic [31:0] i_rdata,
  // load/store requester
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] d_rdata,
  // memory controller side
  output logic        mem_rw_req,
  output logic [31:0] mem_address,
  output logic        mem_rw,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_data_valid,
  // status
  output logic        busy,
  output logic        owner_d
);

  // Timer only has to reach TIMEOUT_CYCLES-1, which fits in clog2(TIMEOUT_CYCLES) bits.
  localparam int              TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit              WDOG_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0]   TIMER_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [3:0]      STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [1:0]      SIZE_WORD  = 2'h2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          owner_q, owner_d_d;
  logic          err_q, err_d;

  logic [31:0]   addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

  logic          grant_fetch;

  // Fetch wins when it is the only requester, or when data has had its fill of grants.
  always_comb begin
    grant_fetch = i_req && (!d_req || (starve_q == STARVE_LIM));
  end

  // Next-state logic: arbitration in IDLE, one-cycle issue, wait with watchdog, one-cycle response.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    timer_d   = timer_q;
    owner_d_d = owner_q;
    err_d     = err_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        // Fetch not waiting means nothing is being starved.
        if (!i_req) begin
          starve_d = '0;
        end
        if (i_req || d_req) begin
          state_d = ST_ISSUE;
          err_d   = 1'b0;
          if (grant_fetch) begin
            owner_d_d = 1'b0;
            addr_d    = i_addr;
            rw_d      = 1'b0;
            size_d    = SIZE_WORD;
            wdata_d   = '0;
            starve_d  = '0;
          end else begin
            owner_d_d = 1'b1;
            addr_d    = d_addr;
            rw_d      = d_rw;
            size_d    = d_size;
            wdata_d   = d_wdata;
            if (i_req) begin
              starve_d = (starve_q == STARVE_LIM) ? starve_q : (starve_q + 4'd1);
            end
          end
        end
      end

      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (mem_data_valid) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          // Writes leave the requester's last read data untouched.
          if (!rw_q) begin
            if (owner_q) begin
              d_rdata_d = mem_read_data;
            end else begin
              i_rdata_d = mem_read_data;
            end
          end
        end else if (WDOG_EN && (timer_q == TIMER_LAST)) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      timer_q  <= '0;
      owner_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      timer_q  <= timer_d;
      owner_q  <= owner_d_d;
      err_q    <= err_d;
    end
  end

  // Transaction fields and returned read data; held between updates so the
  // controller can sample rw/write data late in the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      rw_q      <= 1'b0;
      size_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Output decode: strobes come straight from the state, so reset clears them at once.
  always_comb begin
    mem_rw_req     = (state_q == ST_ISSUE);
    busy           = (state_q != ST_IDLE);
    i_done         = (state_q == ST_RESP) && !owner_q;
    d_done         = (state_q == ST_RESP) && owner_q;
    i_err          = i_done && err_q;
    d_err          = d_done && err_q;
    owner_d        = owner_q;
    mem_address    = addr_q;
    mem_rw         = rw_q;
    mem_size       = size_q;
    mem_write_data = wdata_q;
    i_rdata        = i_rdata_q;
    d_rdata        = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed opening scenarios followed by random
// request traffic, checked against a transaction-level model of the
// arbitration, latency and watchdog rules.
module tb_mem_arbiter;
  localparam int SMAX = 4;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_done, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_size = '0;
  logic        d_done, d_err;
  logic [31:0] d_rdata;
  logic        mem_rw_req;
  logic [31:0] mem_address;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = '0;
  logic        mem_data_valid = 1'b0;
  logic        busy, owner_d;

  mem_arbiter #(.STARVE_MAX(SMAX), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_rw_req(mem_rw_req), .mem_address(mem_address), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_data_valid(mem_data_valid), .busy(busy), .owner_d(owner_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state
  int          starve_m = 0;
  logic [31:0] ird_m = '0;
  logic [31:0] drd_m = '0;
  bit          in_resp = 1'b0;
  bit          last_fw = 1'b0;
  // Scenario knobs: force_lat 0 = random, -1 = controller never answers
  int          force_lat = 0;
  bit          use_force_data = 1'b0;
  logic [31:0] force_data = '0;
  bit          reset_at_wait = 1'b0;
  int          tmo_budget = 2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_daddr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FF00;
    return a;
  endfunction

  task automatic new_fetch();
    i_req  = 1'b1;
    i_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_data();
    d_req   = 1'b1;
    d_rw    = 1'($urandom_range(0, 1));
    d_addr  = pick_daddr();
    d_wdata = $urandom;
    d_size  = 2'($urandom_range(0, 2));
  endtask

  // Requester behaviour: the completed owner drops or renews; idle requesters may start.
  task automatic decide(input bit both);
    if (in_resp) begin
      if (last_fw) begin
        if (both || $urandom_range(0, 1) == 1) new_fetch(); else i_req = 1'b0;
      end else begin
        if (both || $urandom_range(0, 1) == 1) new_data(); else d_req = 1'b0;
      end
    end
    if (!i_req && (both || $urandom_range(0, 2) == 0)) new_fetch();
    if (!d_req && (both || $urandom_range(0, 2) == 0)) new_data();
  endtask

  // From a RESP cycle, step into the following IDLE cycle.
  task automatic settle_to_idle();
    if (in_resp) begin
      @(negedge clk);
      in_resp = 1'b0;
      chk("idle_busy", 32'(busy), 0);
      chk("idle_req", 32'(mem_rw_req), 0);
      chk("idle_done", 32'({i_done, d_done}), 0);
    end
  endtask

  // Called at the negedge of an IDLE cycle whose request inputs are already set.
  task automatic serve();
    bit          fw, tmo, erw;
    int          lat;
    logic [31:0] ea, ew, rd;
    logic [1:0]  es;
    if (!i_req && !d_req) begin
      starve_m = 0;
      if (force_lat == 0 && $urandom_range(0, 3) == 0) begin
        mem_data_valid = 1'b1;       // stray completion outside WAIT
        mem_read_data  = $urandom;
      end
      @(negedge clk);
      mem_data_valid = 1'b0;
      chk("noreq_busy", 32'(busy), 0);
      chk("noreq_done", 32'({i_done, d_done}), 0);
      chk("noreq_rdata_i", i_rdata, ird_m);
      chk("noreq_rdata_d", d_rdata, drd_m);
      return;
    end
    fw = i_req && (!d_req || starve_m == SMAX);
    if (fw) begin
      starve_m = 0;
      ea = i_addr; erw = 1'b0; es = 2'h2; ew = '0;
    end else begin
      starve_m = i_req ? ((starve_m < SMAX) ? starve_m + 1 : SMAX) : 0;
      ea = d_addr; erw = d_rw; es = d_size; ew = d_wdata;
    end
    last_fw = fw;
    if (force_lat == 0) begin
      tmo = (tmo_budget > 0) && ($urandom_range(0, 19) == 0);
      if (tmo) tmo_budget--;
      lat = $urandom_range(1, 6);
    end else begin
      tmo = (force_lat < 0);
      lat = force_lat;
    end
    rd = use_force_data ? force_data : $urandom;

    @(negedge clk);  // ISSUE
    chk("issue_req", 32'(mem_rw_req), 1);
    chk("issue_busy", 32'(busy), 1);
    chk("issue_owner", 32'(owner_d), 32'(!fw));
    chk("issue_addr", mem_address, ea);
    chk("issue_rw", 32'(mem_rw), 32'(erw));
    chk("issue_size", 32'(mem_size), 32'(es));
    if (!fw) chk("issue_wdata", mem_write_data, ew);
    chk("issue_done", 32'({i_done, d_done}), 0);

    for (int k = 1; k <= (tmo ? TMO : lat); k++) begin
      @(negedge clk);  // WAIT
      chk("wait_req", 32'(mem_rw_req), 0);
      chk("wait_busy", 32'(busy), 1);
      chk("wait_addr", mem_address, ea);
      chk("wait_rw", 32'(mem_rw), 32'(erw));
      chk("wait_size", 32'(mem_size), 32'(es));
      if (!fw) chk("wait_wdata", mem_write_data, ew);
      chk("wait_done", 32'({i_done, d_done}), 0);
      if (reset_at_wait && k == 2) begin
        reset_at_wait = 1'b0;
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_data_valid = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(mem_rw_req), 0);
        chk("rst_done", 32'({i_done, d_done, i_err, d_err}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner_d), 0);
        chk("rst_irdata", i_rdata, 0);
        chk("rst_drdata", d_rdata, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_fields", 32'({mem_rw, mem_size}), 0);
        chk("rst_wdata", mem_write_data, 0);
        reset = 1'b0;
        starve_m = 0; ird_m = '0; drd_m = '0; in_resp = 1'b0;
        return;
      end
      if (force_lat == 0 && k == 1 && $urandom_range(0, 7) == 0) begin
        if (fw) i_req = 1'b0; else d_req = 1'b0;   // early drop must not cancel
      end
      if (!tmo && k == lat) begin
        mem_data_valid = 1'b1;
        mem_read_data  = rd;
      end
    end

    @(negedge clk);  // RESP
    mem_data_valid = 1'b0;
    if (!tmo && !erw) begin
      if (fw) ird_m = rd; else drd_m = rd;
    end
    chk("resp_idone", 32'(i_done), 32'(fw));
    chk("resp_ddone", 32'(d_done), 32'(!fw));
    chk("resp_err", 32'(fw ? i_err : d_err), 32'(tmo));
    chk("resp_irdata", i_rdata, ird_m);
    chk("resp_drdata", d_rdata, drd_m);
    chk("resp_req", 32'(mem_rw_req), 0);
    in_resp = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_req", 32'(mem_rw_req), 0);
    chk("reset_done", 32'({i_done, d_done, i_err, d_err}), 0);
    chk("reset_owner", 32'(owner_d), 0);
    chk("reset_rdata", i_rdata | d_rdata, 0);
    chk("reset_mem", mem_address | mem_write_data, 0);
    reset = 1'b0;

    // Single fetch with a 5-cycle controller answer.
    use_force_data = 1'b1;
    force_data = 32'h00A0_0093;
    force_lat = 5;
    i_req = 1'b1; i_addr = 32'h20;
    serve();
    i_req = 1'b0;
    settle_to_idle();

    // Half-word write: fields held, read data untouched.
    force_lat = 3;
    force_data = 32'hDEAD_BEEF;
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h100; d_size = 2'd1; d_wdata = 32'h1234;
    serve();
    d_req = 1'b0;
    settle_to_idle();

    // Simultaneous requests: data first, then fetch.
    use_force_data = 1'b0;
    force_lat = 2;
    new_fetch();
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'hFFFF_FF00; d_size = 2'd2; d_wdata = 32'h0;
    serve();
    d_req = 1'b0;
    settle_to_idle();
    serve();
    i_req = 1'b0;
    settle_to_idle();

    // Controller never answers: watchdog completes with error, then normal service.
    force_lat = -1;
    new_data(); d_rw = 1'b0;
    serve();
    d_req = 1'b0;
    settle_to_idle();
    force_lat = 2;
    new_fetch();
    serve();
    i_req = 1'b0;
    settle_to_idle();

    // Reset in the middle of WAIT, then a fetch completes normally.
    force_lat = 4;
    reset_at_wait = 1'b1;
    new_data(); d_rw = 1'b0;
    serve();
    force_lat = 3;
    new_fetch();
    serve();
    i_req = 1'b0;
    settle_to_idle();

    // Random traffic.
    force_lat = 0;
    for (int n = 0; n < 60; n++) begin
      decide(1'b0);
      settle_to_idle();
      serve();
    end
    // Both requesters continuously busy: starvation guard pattern.
    for (int n = 0; n < 30; n++) begin
      decide(1'b1);
      settle_to_idle();
      serve();
    end
    // More random traffic.
    for (int n = 0; n < 40; n++) begin
      decide(1'b0);
      settle_to_idle();
      serve();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter that shares the single SRAM memory controller between the CPU instruction-fetch path and the load/store data path. It accepts one transaction at a time and drives the controller's request/address/rw/size/write-data interface. It routes the controller's read data and completion back to the winning requester. Data accesses have priority, with a starvation guard for fetch and a watchdog timeout for hung transactions.

Parameters:
STARVE_MAX, 4, max consecutive data grants while fetch is pending before fetch is forced to win (1..15)
TIMEOUT_CYCLES, 64, cycles in WAIT without mem_data_valid before the transaction is aborted; 0 disables the watchdog

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request, level, held until i_done
i_addr  in  32  fetch address; fetch is always a word read (size 2'h2, rw 0)
i_done  out  1  one-cycle completion pulse to fetch
i_err  out  1  valid with i_done: 1 = timed out
i_rdata  out  32  fetch read data, valid with i_done, held until next fetch completion
d_req  in  1  data request, level, held until d_done
d_rw  in  1  0 read, 1 write
d_addr  in  32  data address
d_wdata  in  32  write data
d_size  in  2  0 byte, 1 half, 2 word
d_done  out  1  one-cycle completion pulse to data path
d_err  out  1  valid with d_done: 1 = timed out
d_rdata  out  32  data read data, valid with d_done, held until next data completion
mem_rw_req  out  1  request pulse to memory controller
mem_address  out  32  to controller
mem_rw  out  1  to controller
mem_size  out  2  to controller
mem_write_data  out  32  to controller
mem_read_data  in  32  from controller
mem_data_valid  in  1  controller completion pulse
busy  out  1  1 in any state except IDLE
owner_d  out  1  1 = current/last transaction belongs to data path

Behaviour:
- Reset (sync, high) forces IDLE. The following outputs are 0 on reset: mem_rw_req, i_done, d_done, i_err, d_err, busy, owner_d, starve count, timer, i_rdata, d_rdata, mem_address, mem_rw, mem_size, mem_write_data. Reset mid-transaction abandons it with no done pulse; the top level resets the controller in the same cycle, using the controller's inverted active-low reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample i_req/d_req. If neither is set, stay. Otherwise pick the winner and latch its fields into the mem_* registers, set owner_d, then go to ISSUE.
- Winner selection: d_req wins unless i_req=1 and starve count == STARVE_MAX, in which case fetch wins.
- Starve count: increments on a data grant while i_req=1, saturating at STARVE_MAX. It clears on any fetch grant or any IDLE cycle with i_req=0.
- ISSUE: mem_rw_req=1 for exactly this one cycle. Clear the timer, go to WAIT.
- WAIT: mem_rw_req=0. mem_address/mem_rw/mem_size/mem_write_data are held stable from ISSUE until leaving WAIT, because the controller samples rw and write_data late.
  - On mem_data_valid=1: capture mem_read_data into i_rdata or d_rdata (reads only; writes leave rdata unchanged), go to RESP with err=0.
  - Else if TIMEOUT_CYCLES!=0 and timer == TIMEOUT_CYCLES-1: go to RESP with err=1, rdata unchanged.
  - Otherwise timer++.
- RESP: owner's done=1 (and err) for this one cycle only; request inputs are ignored here. Next state is IDLE.
- Requester protocol: keep req and fields stable until done. After done, either drop req in the next cycle, or keep it high with new fields to get a back-to-back transaction, sampled in the following IDLE.
- A requester deasserting req early does not cancel an in-flight transaction; done still pulses.
- Latency: req high in IDLE cycle c -> mem_rw_req at c+1. If mem_data_valid arrives at cycle v, done is asserted at v+1 and the next mem_rw_req is at v+3 at the earliest. This satisfies the controller's one-cycle post-valid idle.
- mem_data_valid outside WAIT is ignored.
- Address 0xFFFFFF00 (port register) passes through unchanged; it is arbitrated like any other access.
- Both requesters asserting in the same IDLE cycle is resolved by the selection rule; the loser simply stays pending.

Test Plan:
- Single fetch i_addr=0x20, controller returns 0x00A00093 after 5 cycles -> mem_rw_req one cycle at c+1, i_done one cycle with i_rdata=0x00A00093, i_err=0, d_done never.
- Data write d_rw=1, d_addr=0x100, d_size=1, d_wdata=0x1234 -> mem_rw/mem_size/mem_write_data stable from ISSUE through valid, d_done pulses, d_rdata unchanged.
- i_req and d_req asserted together in the same cycle -> data served first, fetch second, no idle gap beyond 1 cycle between RESP and next ISSUE.
- d_req held continuously with back-to-back requests plus i_req high, STARVE_MAX=4 -> exactly 4 data grants then 1 fetch grant, repeating.
- Controller never returns valid, TIMEOUT_CYCLES=64 -> d_done with d_err=1 exactly 64 WAIT cycles after ISSUE, FSM back in IDLE, next request served normally.
- reset asserted during WAIT -> next cycle IDLE, all outputs 0, no done pulse; subsequent fetch completes correctly.
